fifo_buffer_ram: RTL and testbench
==================================

// Module: fifo_buffer_ram
// PURPOSE
// - Storage-side responder for the FIFO controller. Consumes wr_en/wr_ptr and rd_en/rd_ptr
//   from the controller, holds the data words and returns read data with a valid strobe.
// - Independently checks the controller's pointer traffic: overflow, underflow, occupancy
//   and illegal pointer distance, so controller bugs surface at the storage boundary.
// PARAMETERS
// - DATA_WIDTH  8   width of one stored word
// - DEPTH       32  number of words; power of two
// - PTR_WIDTH   6   controller pointer width = log2(DEPTH)+1; MSB is the wrap bit
// PORTS
// - clk        in   1           single clock; all logic on posedge
// - rst        in   1           asynchronous, active-low reset
// - wr_en      in   1           write strobe from controller
// - wr_ptr     in   PTR_WIDTH   write pointer; [PTR_WIDTH-2:0] = address, MSB = wrap
// - wr_data    in   DATA_WIDTH  word to store
// - rd_en      in   1           read strobe from controller
// - rd_ptr     in   PTR_WIDTH   read pointer; same encoding as wr_ptr
// - rd_data    out  DATA_WIDTH  registered read data
// - rd_valid   out  1           rd_data holds a word from an accepted read
// - bypass     out  1           qualifies rd_data as forwarded wr_data (empty-collision)
// - level      out  PTR_WIDTH   registered occupancy = (wr_ptr - rd_ptr) mod 2^PTR_WIDTH
// - ovf_err    out  1           one-cycle pulse: write rejected, buffer full
// - udf_err    out  1           one-cycle pulse: read rejected, buffer empty
// - ptr_err    out  1           sticky: level ever exceeded DEPTH
// BEHAVIOUR
// - Reset (rst=0, async): rd_data=0, rd_valid=0, bypass=0, level=0, ovf_err=0, udf_err=0,
//   ptr_err=0. Memory array is not reset. Reset mid-operation drops any in-flight read.
// - Combinational: occ = wr_ptr - rd_ptr (PTR_WIDTH bits, wraps); empty = (occ==0);
//   full = (occ==DEPTH). Address uses only the low PTR_WIDTH-1 bits; wrap is implicit.
// - Write: wr_en & !(full & !rd_en) -> mem[wr_addr] <= wr_data at the posedge.
//   wr_en & full & !rd_en -> write suppressed, ovf_err=1 next cycle.
// - Read: rd_en & !empty -> rd_data <= mem[rd_addr], rd_valid=1 next cycle (latency 1).
//   rd_en & empty & !wr_en -> read suppressed, rd_valid=0, udf_err=1 next cycle.
//   !rd_en -> rd_valid=0, rd_data holds its last value.
// - Collision, full pointer equal (empty) and wr_en & rd_en: write accepted, rd_data <=
//   wr_data (write-first forward), rd_valid=1, bypass=1 next cycle; no udf_err.
// - Collision, same address, wrap bits differ (full) and wr_en & rd_en: read returns old
//   stored word (read-before-write), write of new word accepted, bypass=0, no ovf_err.
// - level <= occ every cycle (reflects pointers sampled at that edge).
// - ptr_err set when occ > DEPTH; held until reset. Data path keeps operating.
// - ovf_err, udf_err, bypass are single-cycle; deassert the cycle after unless re-triggered.
// CONFIGURATION
// - FIFO_RAM_OREG_EN defined: extra output register stage after the read register;
//   rd_data, rd_valid, bypass have latency 2 and move together. level/ovf_err/udf_err/
//   ptr_err timing unchanged. Stage resets to 0 with the rest.
// - FIFO_RAM_OREG_EN undefined: read latency 1 as above; no extra stage.
// TESTING
// - Reset, then write 0xA5 at ptr 0, rd_en at rd_ptr 0 (wr_ptr 1) -> next cycle rd_data=0xA5,
//   rd_valid=1, level=1.
// - Fill 32 words (wr_ptr 0..31 -> 32), then wr_en at wr_ptr 32, rd_ptr 0 -> ovf_err=1 one
//   cycle, mem[0] unchanged, level=32.
// - rd_en with rd_ptr=wr_ptr=5, no wr_en -> udf_err=1, rd_valid=0; with wr_en, wr_data=0x3C
//   -> rd_data=0x3C, rd_valid=1, bypass=1.
// - Full, rd_ptr=0, wr_ptr=32, both enables, wr_data=0x77 over stored 0x11 -> rd_data=0x11,
//   then read at ptr 32 returns 0x77.
// - Stream 100 words through with wrapping pointers (wrap bit toggles) -> all data in order,
//   no errors; force wr_ptr-rd_ptr=40 -> ptr_err=1, stays 1 until rst=0.
// - Pull rst low with a read in flight -> rd_valid=0, all outputs 0 immediately; rebuild
//   with FIFO_RAM_OREG_EN -> first test shows rd_valid after 2 cycles.

Source files
------------

// File: rtl/fifo_buffer_ram.sv
// Storage-side responder for a FIFO controller: word store, registered read port and pointer-traffic checking.
// Optional macro FIFO_RAM_OREG_EN adds a second output register stage (read latency 2).
module fifo_buffer_ram #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 32,
    parameter int PTR_WIDTH  = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [PTR_WIDTH-1:0]  wr_ptr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [PTR_WIDTH-1:0]  rd_ptr,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic                  bypass,
    output logic [PTR_WIDTH-1:0]  level,
    output logic                  ovf_err,
    output logic                  udf_err,
    output logic                  ptr_err
);

    localparam int ADDR_WIDTH = PTR_WIDTH - 1;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [PTR_WIDTH-1:0]  occ;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic                  empty;
    logic                  full;
    logic                  fwd;
    logic                  rd_accept;
    logic                  wr_accept;
    logic                  ovf_hit;
    logic                  udf_hit;

    // Pointer difference wraps modulo 2^PTR_WIDTH; the MSB disambiguates full from empty.
    assign occ       = wr_ptr - rd_ptr;
    assign wr_addr   = wr_ptr[ADDR_WIDTH-1:0];
    assign rd_addr   = rd_ptr[ADDR_WIDTH-1:0];
    assign empty     = (occ == '0);
    assign full      = (occ == PTR_WIDTH'(DEPTH));
    assign fwd       = wr_en & rd_en & empty;
    assign rd_accept = rd_en & ~empty;
    assign ovf_hit   = wr_en & full & ~rd_en;
    assign udf_hit   = rd_en & empty & ~wr_en;
    assign wr_accept = wr_en & ~ovf_hit;

    // NOTE: the storage array has no reset; clearing it would turn the RAM into a flop bank.
    always_ff @(posedge clk) begin
        if (wr_accept) begin
            mem[wr_addr] <= wr_data;
        end
    end

    logic [DATA_WIDTH-1:0] s1_data;
    logic                  s1_valid;
    logic                  s1_bypass;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_data   <= '0;
            s1_valid  <= 1'b0;
            s1_bypass <= 1'b0;
            level     <= '0;
            ovf_err   <= 1'b0;
            udf_err   <= 1'b0;
            ptr_err   <= 1'b0;
        end else begin
            s1_valid  <= rd_accept | fwd;
            s1_bypass <= fwd;
            if (fwd) begin
                s1_data <= wr_data;
            end else if (rd_accept) begin
                // Same-address full collision reads the old word: the write lands at this same edge.
                s1_data <= mem[rd_addr];
            end
            level   <= occ;
            ovf_err <= ovf_hit;
            udf_err <= udf_hit;
            if (occ > PTR_WIDTH'(DEPTH)) begin
                ptr_err <= 1'b1;
            end
        end
    end

`ifdef FIFO_RAM_OREG_EN
    logic [DATA_WIDTH-1:0] s2_data;
    logic                  s2_valid;
    logic                  s2_bypass;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s2_data   <= '0;
            s2_valid  <= 1'b0;
            s2_bypass <= 1'b0;
        end else begin
            s2_data   <= s1_data;
            s2_valid  <= s1_valid;
            s2_bypass <= s1_bypass;
        end
    end

    assign rd_data  = s2_data;
    assign rd_valid = s2_valid;
    assign bypass   = s2_bypass;
`else
    assign rd_data  = s1_data;
    assign rd_valid = s1_valid;
    assign bypass   = s1_bypass;
`endif

endmodule

// File: tb/tb_fifo_buffer_ram.sv
// Self-checking bench for fifo_buffer_ram: directed corner cases plus a random stream
// checked against a queue-based FIFO reference model.
module tb_fifo_buffer_ram;

`ifdef FIFO_RAM_OREG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       wr_en;
    logic [5:0] wr_ptr;
    logic [7:0] wr_data;
    logic       rd_en;
    logic [5:0] rd_ptr;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       bypass;
    logic [5:0] level;
    logic       ovf_err;
    logic       udf_err;
    logic       ptr_err;

    int total = 0;
    int bad   = 0;

    // Reference state: stored words in FIFO order, the controller's pointers, held read data.
    logic [7:0] q[$];
    logic [5:0] wp, rp;
    logic [7:0] hold;
    logic       exp_perr;
    logic       pv [2];
    logic       pb [2];
    logic [7:0] pd [2];

    fifo_buffer_ram dut (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_ptr  (wr_ptr),
        .wr_data (wr_data),
        .rd_en   (rd_en),
        .rd_ptr  (rd_ptr),
        .rd_data (rd_data),
        .rd_valid(rd_valid),
        .bypass  (bypass),
        .level   (level),
        .ovf_err (ovf_err),
        .udf_err (udf_err),
        .ptr_err (ptr_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_clear();
        q.delete();
        wp       = '0;
        rp       = '0;
        hold     = '0;
        exp_perr = 1'b0;
        for (int i = 0; i < 2; i++) begin
            pv[i] = 1'b0;
            pb[i] = 1'b0;
            pd[i] = '0;
        end
    endtask

    // Pull reset low (possibly mid-read), confirm all outputs clear at once, release on a falling edge.
    task automatic do_reset(input string tag);
        rst = 1'b0;
        #1;
        check({tag, "_rd_valid"}, rd_valid, 0);
        check({tag, "_rd_data"},  rd_data,  0);
        check({tag, "_bypass"},   bypass,   0);
        check({tag, "_level"},    level,    0);
        check({tag, "_ovf"},      ovf_err,  0);
        check({tag, "_udf"},      udf_err,  0);
        check({tag, "_ptr_err"},  ptr_err,  0);
        model_clear();
        wr_en = 1'b0;
        rd_en = 1'b0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    // One controller cycle at the reference pointers; predicts from FIFO semantics, then checks.
    task automatic drive(input string tag, input logic we, input logic [7:0] wd, input logic re);
        logic [5:0] occ;
        logic       e_ovf, e_udf, nv, nb;
        logic [7:0] nd;
        occ     = wp - rp;
        wr_en   = we;
        wr_data = wd;
        rd_en   = re;
        wr_ptr  = wp;
        rd_ptr  = rp;
        e_ovf   = we && occ == 6'd32 && !re;
        e_udf   = re && occ == 6'd0 && !we;
        nv = 1'b0;
        nb = 1'b0;
        nd = hold;
        if (we && re && occ == 6'd0) begin
            nv = 1'b1;
            nb = 1'b1;
            nd = wd;
            wp++;
            rp++;
        end else begin
            if (re && occ != 6'd0) begin
                nv = 1'b1;
                if (q.size() > 0) nd = q.pop_front();
                rp++;
            end
            if (we && !e_ovf) begin
                q.push_back(wd);
                wp++;
            end
        end
        hold = nd;
        if (occ > 6'd32) exp_perr = 1'b1;
        pv[1] = pv[0]; pb[1] = pb[0]; pd[1] = pd[0];
        pv[0] = nv;    pb[0] = nb;    pd[0] = nd;
        @(posedge clk);
        #1;
        check({tag, "_level"},    level,    occ);
        check({tag, "_ovf"},      ovf_err,  e_ovf);
        check({tag, "_udf"},      udf_err,  e_udf);
        check({tag, "_ptr_err"},  ptr_err,  exp_perr);
        check({tag, "_rd_valid"}, rd_valid, pv[LAT-1]);
        check({tag, "_rd_data"},  rd_data,  pd[LAT-1]);
        check({tag, "_bypass"},   bypass,   pb[LAT-1]);
    endtask

    initial begin
        rst     = 1'b0;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        wr_ptr  = '0;
        rd_ptr  = '0;
        wr_data = '0;
        model_clear();
        #3;
        do_reset("init");

        // Single write then read of 0xA5.
        drive("wr_a5", 1'b1, 8'hA5, 1'b0);
        drive("rd_a5", 1'b0, 8'h00, 1'b1);
        for (int i = 0; i < LAT; i++) drive("idle_a5", 1'b0, 8'h00, 1'b0);

        // Fill to full, rejected write, full collision, then drain.
        do_reset("pre_fill");
        drive("fill", 1'b1, 8'h11, 1'b0);
        for (int i = 1; i < 32; i++) drive("fill", 1'b1, 8'($urandom), 1'b0);
        drive("ovf", 1'b1, 8'h99, 1'b0);
        drive("after_ovf", 1'b0, 8'h00, 1'b0);
        drive("full_coll", 1'b1, 8'h77, 1'b1);
        for (int i = 0; i < 32; i++) drive("drain", 1'b0, 8'h00, 1'b1);
        for (int i = 0; i < LAT; i++) drive("idle_drain", 1'b0, 8'h00, 1'b0);

        // Empty at pointer 5: underflow, then write-first forward.
        do_reset("pre_udf");
        wp = 6'd5;
        rp = 6'd5;
        drive("udf", 1'b0, 8'h00, 1'b1);
        drive("fwd", 1'b1, 8'h3C, 1'b1);
        for (int i = 0; i < LAT + 1; i++) drive("idle_fwd", 1'b0, 8'h00, 1'b0);

        // Random stream with wrapping pointers.
        for (int i = 0; i < 400; i++) begin
            drive("rand", 1'($urandom_range(0, 99) < 55), 8'($urandom), 1'($urandom_range(0, 99) < 50));
        end
        while (wp != rp) drive("flush", 1'b0, 8'h00, 1'b1);
        for (int i = 0; i < LAT; i++) drive("idle_flush", 1'b0, 8'h00, 1'b0);

        // Illegal pointer distance: ptr_err is sticky until reset.
        begin
            logic [5:0] save_wp;
            save_wp = wp;
            wp = rp + 6'd40;
            drive("ptr40", 1'b0, 8'h00, 1'b0);
            wp = save_wp;
            drive("ptr_sticky", 1'b0, 8'h00, 1'b0);
            drive("ptr_sticky2", 1'b1, 8'h42, 1'b0);
        end

        // Reset with a read in flight.
        do_reset("pre_mid");
        drive("mid_wr", 1'b1, 8'h5A, 1'b0);
        wr_en  = 1'b0;
        rd_en  = 1'b1;
        rd_ptr = rp;
        wr_ptr = wp;
        @(posedge clk);
        #1;
        do_reset("mid_rst");
        drive("post_rst", 1'b0, 8'h00, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
